escalonador_passos: RTL and testbench
=====================================

Name: escalonador_passos

Overview:
Timing scheduler for the drone game datapath. It generates the `fim_espera` pulses that pace each drone step, and the step period depends on the selected difficulty mode. It counts completed horizontal displacements, speeds up the game every PASSOS_NIVEL steps by shortening the period, and raises `fim_mapa` when the map length is reached. It sits between the game control FSM and the datapath: it consumes `contaT`, `zeraT` and `desloca_horizontal`, and returns `fim_espera` and `fim_mapa`.

Parameters:
- W, 26: width of the timer and period registers; every period parameter must fit in W bits.
- PERIODO_FACIL, 50000000: step period in clocks for mode 00.
- PERIODO_MEDIO, 25000000: step period in clocks for mode 01.
- PERIODO_DIFICIL, 12500000: step period in clocks for modes 10 and 11.
- DECREMENTO, 2500000: clocks removed from the period at each level-up.
- PERIODO_MIN, 5000000: floor for the period; must be at least 2.
- PASSOS_NIVEL, 8: steps per level.
- COMPRIMENTO_MAPA, 64: total steps to finish the map; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- modo_sel  in  2  difficulty selection; sampled only when `carrega`=1.
- carrega  in  1  start-of-game load, driven from the preparacao state.
- contaT  in  1  timer enable; high while the control FSM is in espera.
- zeraT  in  1  clears the timer only.
- passo_ok  in  1  one-cycle pulse meaning a displacement was done (`desloca_horizontal`).
- fim_espera  out  1  registered one-cycle pulse marking the end of the step period.
- fim_mapa  out  1  level output; high once the map is complete.
- nivel  out  3  current speed level, saturating at 7.
- db_periodo  out  W  current period, for debug.
- db_estado  out  4  FSM state code, for debug.

Behaviour:
- Reset (synchronous, at the clock edge with `reset`=1):
  - state OCIOSO; timer=0, passos=0, passos_nivel=0, nivel=0.
  - periodo=PERIODO_FACIL.
  - fim_espera=0, fim_mapa=0.
- Priority order: reset, then carrega, then zeraT, then normal FSM operation.
- carrega=1, in any state:
  - periodo loaded from modo_sel: 00 gives FACIL, 01 gives MEDIO, 1x gives DIFICIL.
  - timer, passos, passos_nivel and nivel cleared; fim_mapa=0, fim_espera=0.
  - next state OCIOSO.
- zeraT=1: timer=0 in that cycle. State is unchanged and the timer does not increment in that cycle.
- States and codes (db_estado): OCIOSO=0, CONTANDO=1, AGUARDA_PASSO=2, FIM=3; any illegal value shows F and recovers to OCIOSO.
- OCIOSO: contaT=1 moves to CONTANDO and this edge already counts, so timer becomes 1.
- CONTANDO:
  - contaT=1 and timer<periodo-1: timer increments.
  - contaT=1 and timer==periodo-1: timer=0, fim_espera=1 in the next cycle only, state moves to AGUARDA_PASSO.
  - contaT=0: timer holds (pause).
  - Net timing: fim_espera appears exactly periodo clocks after the first contaT cycle, provided contaT stays high.
- AGUARDA_PASSO: the timer is frozen and contaT is ignored. On passo_ok:
  - passos+1==COMPRIMENTO_MAPA: go to FIM, fim_mapa=1 from the next cycle.
  - else, if passos_nivel+1==PASSOS_NIVEL:
    - passos_nivel=0.
    - nivel increments, saturating at 7.
    - periodo = max(periodo-DECREMENTO, PERIODO_MIN), computed without underflow: if periodo < PERIODO_MIN+DECREMENTO, then periodo = PERIODO_MIN.
    - A period change takes effect on the next count.
  - passos and passos_nivel otherwise increment; state returns to CONTANDO.
- passo_ok outside AGUARDA_PASSO is ignored.
- FIM: fim_mapa is held and fim_espera stays 0. Only carrega or reset leaves this state.
- fim_espera is never high for two consecutive cycles.
- passos width is clog2(COMPRIMENTO_MAPA+1); passos_nivel width is clog2(PASSOS_NIVEL+1).

Decomposition:
- Shared package `escalonador_pkg`:
  - mode encodings MODO_FACIL=2'b00, MODO_MEDIO=2'b01, MODO_DIFICIL=2'b10;
  - state codes OCIOSO, CONTANDO, AGUARDA_PASSO, FIM;
  - db_estado illegal code 4'hF.
- One sub-module, `contador_periodo`: a W-bit counter with inputs clear, enable and limit, and a terminal output fim (timer==limit-1 and enable). The FSM, step counters and period update logic stay in the top module.

Test Plan (all scenarios use W=8, FACIL=8, MEDIO=6, DIFICIL=4, DECREMENTO=2, MIN=2, PASSOS_NIVEL=2, COMPRIMENTO_MAPA=6):
1. reset, carrega with modo_sel=00, then contaT held high -> fim_espera is a single pulse exactly 8 clocks after contaT rose; db_estado=2 afterwards; db_periodo=8.
2. Mode 01, contaT high for 3 cycles, low for 5, then high again -> fim_espera after 6 counting cycles in total; the timer holds during the pause.
3. Mode 10, two step cycles, each with passo_ok one cycle after fim_espera -> after the 2nd passo_ok, nivel=1, db_periodo=2 (4-2), and the next fim_espera comes 2 clocks after contaT.
4. Continue to 6 steps -> the period stays at MIN=2 with no underflow; fim_mapa=1 one cycle after the 6th passo_ok; db_estado=3; later contaT and passo_ok cause no fim_espera.
5. zeraT pulsed mid-count while in CONTANDO with timer=5 (mode 00) -> timer=0 and fim_espera arrives 8 counting clocks after zeraT; passo_ok injected during CONTANDO -> passos unchanged.
6. reset asserted while in AGUARDA_PASSO with nivel=2 -> next cycle all outputs are at reset values and db_periodo=8; carrega in FIM with modo_sel=01 -> fim_mapa=0, db_periodo=6, db_estado=0.

Source files
------------

// File: rtl/escalonador_pkg.sv
// Shared encodings for the drone step scheduler: difficulty modes,
// FSM states and the debug code shown for an unreachable state.
package escalonador_pkg;

  localparam logic [1:0] MODO_FACIL   = 2'b00;
  localparam logic [1:0] MODO_MEDIO   = 2'b01;
  localparam logic [1:0] MODO_DIFICIL = 2'b10;

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    CONTANDO      = 4'd1,
    AGUARDA_PASSO = 4'd2,
    FIM           = 4'd3
  } estado_t;

  localparam logic [3:0] ESTADO_ILEGAL = 4'hF;

  function automatic logic [3:0] codigo_estado(input estado_t e);
    logic [3:0] codigo;
    case (e)
      OCIOSO, CONTANDO, AGUARDA_PASSO, FIM: codigo = 4'(e);
      default:                              codigo = ESTADO_ILEGAL;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/escalonador_passos_contador_periodo.sv
// W-bit step timer: counts while enabled, wraps to zero on the terminal
// count (limit-1) and flags that cycle on fim.
module contador_periodo #(
  parameter int W = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         fim
);

  logic [W-1:0] contagem_q, contagem_d;

  assign fim = enable && (contagem_q == (limit - W'(1)));

  always_comb begin
    contagem_d = contagem_q;
    if (clear) begin
      contagem_d = '0;
    end else if (enable) begin
      contagem_d = fim ? '0 : (contagem_q + W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

endmodule

// File: rtl/escalonador_passos.sv
// Step scheduler: paces drone steps with fim_espera, speeds up every
// PASSOS_NIVEL steps and flags fim_mapa once the map length is reached.
module escalonador_passos
  import escalonador_pkg::*;
#(
  parameter int W                = 26,
  parameter int PERIODO_FACIL    = 50000000,
  parameter int PERIODO_MEDIO    = 25000000,
  parameter int PERIODO_DIFICIL  = 12500000,
  parameter int DECREMENTO       = 2500000,
  parameter int PERIODO_MIN      = 5000000,
  parameter int PASSOS_NIVEL     = 8,
  parameter int COMPRIMENTO_MAPA = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   modo_sel,
  input  logic         carrega,
  input  logic         contaT,
  input  logic         zeraT,
  input  logic         passo_ok,
  output logic         fim_espera,
  output logic         fim_mapa,
  output logic [2:0]   nivel,
  output logic [W-1:0] db_periodo,
  output logic [3:0]   db_estado
);

  localparam int PW = $clog2(COMPRIMENTO_MAPA + 1);
  localparam int NW = $clog2(PASSOS_NIVEL + 1);

  localparam logic [W-1:0]  P_FACIL   = W'(PERIODO_FACIL);
  localparam logic [W-1:0]  P_MEDIO   = W'(PERIODO_MEDIO);
  localparam logic [W-1:0]  P_DIFICIL = W'(PERIODO_DIFICIL);
  localparam logic [W-1:0]  P_DEC     = W'(DECREMENTO);
  localparam logic [W-1:0]  P_MIN     = W'(PERIODO_MIN);
  localparam logic [W:0]    LIMIAR    = (W+1)'(PERIODO_MIN + DECREMENTO);
  localparam logic [PW-1:0] MAPA_FIM  = PW'(COMPRIMENTO_MAPA);
  localparam logic [NW-1:0] NIVEL_FIM = NW'(PASSOS_NIVEL);

  estado_t       estado_q, estado_d;
  logic [W-1:0]  periodo_q, periodo_d;
  logic [PW-1:0] passos_q, passos_d;
  logic [NW-1:0] passos_nivel_q, passos_nivel_d;
  logic [2:0]    nivel_q, nivel_d;
  logic          fim_espera_q, fim_espera_d;
  logic          fim_mapa_q, fim_mapa_d;

  logic          tmr_clear, tmr_enable, tmr_fim;
  logic [W-1:0]  periodo_modo, periodo_reduzido;
  logic [PW-1:0] passos_inc;
  logic [NW-1:0] passos_nivel_inc;

  contador_periodo #(.W(W)) u_contador (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (periodo_q),
    .fim    (tmr_fim)
  );

  always_comb begin
    case (modo_sel)
      MODO_FACIL: periodo_modo = P_FACIL;
      MODO_MEDIO: periodo_modo = P_MEDIO;
      default:    periodo_modo = P_DIFICIL;
    endcase
  end

  // The floor test is done before subtracting so the period never wraps.
  assign periodo_reduzido = ({1'b0, periodo_q} < LIMIAR) ? P_MIN : (periodo_q - P_DEC);
  assign passos_inc       = passos_q + PW'(1);
  assign passos_nivel_inc = passos_nivel_q + NW'(1);

  always_comb begin
    estado_d       = estado_q;
    periodo_d      = periodo_q;
    passos_d       = passos_q;
    passos_nivel_d = passos_nivel_q;
    nivel_d        = nivel_q;
    fim_espera_d   = 1'b0;
    fim_mapa_d     = fim_mapa_q;
    tmr_clear      = 1'b0;
    tmr_enable     = 1'b0;

    if (carrega) begin
      periodo_d      = periodo_modo;
      passos_d       = '0;
      passos_nivel_d = '0;
      nivel_d        = '0;
      fim_mapa_d     = 1'b0;
      tmr_clear      = 1'b1;
      estado_d       = OCIOSO;
    end else if (zeraT) begin
      tmr_clear = 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (contaT) begin
            tmr_enable = 1'b1;
            estado_d   = CONTANDO;
          end
        end
        CONTANDO: begin
          tmr_enable = contaT;
          if (tmr_fim) begin
            fim_espera_d = 1'b1;
            estado_d     = AGUARDA_PASSO;
          end
        end
        AGUARDA_PASSO: begin
          if (passo_ok) begin
            passos_d = passos_inc;
            if (passos_inc == MAPA_FIM) begin
              fim_mapa_d = 1'b1;
              estado_d   = FIM;
            end else begin
              if (passos_nivel_inc == NIVEL_FIM) begin
                passos_nivel_d = '0;
                periodo_d      = periodo_reduzido;
                if (nivel_q != 3'd7) nivel_d = nivel_q + 3'd1;
              end else begin
                passos_nivel_d = passos_nivel_inc;
              end
              estado_d = CONTANDO;
            end
          end
        end
        FIM: begin
          fim_mapa_d = 1'b1;
        end
        default: begin
          tmr_clear = 1'b1;
          estado_d  = OCIOSO;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      periodo_q      <= P_FACIL;
      passos_q       <= '0;
      passos_nivel_q <= '0;
      nivel_q        <= '0;
      fim_espera_q   <= 1'b0;
      fim_mapa_q     <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      periodo_q      <= periodo_d;
      passos_q       <= passos_d;
      passos_nivel_q <= passos_nivel_d;
      nivel_q        <= nivel_d;
      fim_espera_q   <= fim_espera_d;
      fim_mapa_q     <= fim_mapa_d;
    end
  end

  assign fim_espera = fim_espera_q;
  assign fim_mapa   = fim_mapa_q;
  assign nivel      = nivel_q;
  assign db_periodo = periodo_q;
  assign db_estado  = codigo_estado(estado_q);

endmodule

// File: tb/tb_escalonador_passos.sv
// Bench for escalonador_passos with small periods: step latencies go
// through an expected queue, status outputs are checked inline per scenario.
module tb_escalonador_passos;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   modo_sel = 2'b00;
  logic         carrega = 1'b0;
  logic         contaT = 1'b0;
  logic         zeraT = 1'b0;
  logic         passo_ok = 1'b0;
  logic         fim_espera;
  logic         fim_mapa;
  logic [2:0]   nivel;
  logic [W-1:0] db_periodo;
  logic [3:0]   db_estado;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  escalonador_passos #(
    .W(8), .PERIODO_FACIL(8), .PERIODO_MEDIO(6), .PERIODO_DIFICIL(4),
    .DECREMENTO(2), .PERIODO_MIN(2), .PASSOS_NIVEL(2), .COMPRIMENTO_MAPA(6)
  ) dut (
    .clock(clock), .reset(reset), .modo_sel(modo_sel), .carrega(carrega),
    .contaT(contaT), .zeraT(zeraT), .passo_ok(passo_ok),
    .fim_espera(fim_espera), .fim_mapa(fim_mapa), .nivel(nivel),
    .db_periodo(db_periodo), .db_estado(db_estado)
  );

  // clock/reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic carregar(input logic [1:0] m);
    modo_sel = m;
    carrega  = 1'b1;
    tick();
    carrega  = 1'b0;
  endtask

  // Holds contaT high until fim_espera; returns the counting cycles (FFFF on timeout).
  task automatic run_step(output logic [15:0] lat);
    int n = 0;
    bit got = 0;
    contaT = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (fim_espera) begin
        got = 1;
        break;
      end
    end
    contaT = 1'b0;
    lat = got ? 16'(n) : 16'hFFFF;
  endtask

  task automatic pulse_passo();
    passo_ok = 1'b1;
    tick();
    passo_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
    checks++; if (db_periodo !== 8'd8) begin errors++; $display("FAIL reset_periodo got=%0d exp=8", db_periodo); end
    checks++; if (nivel !== 3'd0) begin errors++; $display("FAIL reset_nivel got=%0d exp=0", nivel); end
    checks++; if (fim_espera !== 1'b0 || fim_mapa !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", fim_espera, fim_mapa); end
  endtask

  task automatic test_facil();
    logic [15:0] lat, e;
    carregar(2'b00);
    exp_q.push_back(16'd8);
    run_step(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== e) begin errors++; $display("FAIL facil_latency got=%0d exp=%0d", lat, e); end
    contaT = 1'b1;
    tick();
    checks++; if (fim_espera !== 1'b0) begin errors++; $display("FAIL facil_single_pulse got=%b exp=0", fim_espera); end
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL facil_estado got=%0d exp=2", db_estado); end
    checks++; if (db_periodo !== 8'd8) begin errors++; $display("FAIL facil_periodo got=%0d exp=8", db_periodo); end
    contaT = 1'b0;
  endtask

  task automatic test_pause();
    logic [15:0] lat, e;
    int n = 0;
    bit early = 0;
    carregar(2'b01);
    exp_q.push_back(16'd6);
    contaT = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); n++; if (fim_espera) early = 1; end
    contaT = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (fim_espera) early = 1; end
    run_step(lat);
    if (lat != 16'hFFFF) lat = lat + 16'(n);
    e = exp_q.pop_front();
    checks++; if (early) begin errors++; $display("FAIL pause_early got=1 exp=0"); end
    checks++; if (lat !== e) begin errors++; $display("FAIL pause_latency got=%0d exp=%0d", lat, e); end
  endtask

  task automatic test_level_up();
    logic [15:0] lat, e;
    logic [15:0] tab [3] = '{16'd4, 16'd4, 16'd2};
    carregar(2'b10);
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(tab[s]);
      run_step(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== e) begin errors++; $display("FAIL level_step%0d_latency got=%0d exp=%0d", s, lat, e); end
      pulse_passo();
      if (s == 1) begin
        checks++; if (nivel !== 3'd1) begin errors++; $display("FAIL level_nivel got=%0d exp=1", nivel); end
        checks++; if (db_periodo !== 8'd2) begin errors++; $display("FAIL level_periodo got=%0d exp=2", db_periodo); end
      end
    end
  endtask

  task automatic test_fim_mapa();
    logic [15:0] lat, e;
    bit saw = 0;
    for (int s = 3; s < 6; s++) begin
      exp_q.push_back(16'd2);
      run_step(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== e) begin errors++; $display("FAIL mapa_step%0d_latency got=%0d exp=%0d", s, lat, e); end
      if (s == 5) begin
        checks++; if (fim_mapa !== 1'b0) begin errors++; $display("FAIL mapa_early got=%b exp=0", fim_mapa); end
      end
      pulse_passo();
      if (s == 3) begin
        checks++; if (db_periodo !== 8'd2 || nivel !== 3'd2) begin errors++; $display("FAIL mapa_floor got=%0d/%0d exp=2/2", db_periodo, nivel); end
      end
    end
    checks++; if (fim_mapa !== 1'b1) begin errors++; $display("FAIL mapa_flag got=%b exp=1", fim_mapa); end
    checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL mapa_estado got=%0d exp=3", db_estado); end
    contaT = 1'b1;
    for (int i = 0; i < 12; i++) begin
      passo_ok = i[0];
      tick();
      if (fim_espera || !fim_mapa) saw = 1;
    end
    contaT = 1'b0;
    passo_ok = 1'b0;
    checks++; if (saw) begin errors++; $display("FAIL mapa_hold got=1 exp=0"); end
  endtask

  task automatic test_zera();
    logic [15:0] lat, e;
    carregar(2'b00);
    contaT = 1'b1;
    tick(); tick();
    passo_ok = 1'b1;
    tick();
    passo_ok = 1'b0;
    tick(); tick();
    checks++; if (fim_espera !== 1'b0 || db_estado !== 4'd1) begin errors++; $display("FAIL zera_pre got=%b/%0d exp=0/1", fim_espera, db_estado); end
    zeraT = 1'b1;
    tick();
    zeraT = 1'b0;
    exp_q.push_back(16'd8);
    run_step(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== e) begin errors++; $display("FAIL zera_latency got=%0d exp=%0d", lat, e); end
    pulse_passo();
    checks++; if (nivel !== 3'd0) begin errors++; $display("FAIL zera_ignored_passo got=%0d exp=0", nivel); end
    exp_q.push_back(16'd8);
    run_step(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== e) begin errors++; $display("FAIL zera_step2_latency got=%0d exp=%0d", lat, e); end
    pulse_passo();
    checks++; if (nivel !== 3'd1 || db_periodo !== 8'd6) begin errors++; $display("FAIL zera_level got=%0d/%0d exp=1/6", nivel, db_periodo); end
  endtask

  task automatic test_reset_reload();
    logic [15:0] lat, e;
    logic [15:0] tab_a [5] = '{16'd8, 16'd8, 16'd6, 16'd6, 16'd4};
    logic [15:0] tab_b [6] = '{16'd4, 16'd4, 16'd2, 16'd2, 16'd2, 16'd2};
    carregar(2'b00);
    for (int s = 0; s < 5; s++) begin
      exp_q.push_back(tab_a[s]);
      run_step(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== e) begin errors++; $display("FAIL reload_a%0d_latency got=%0d exp=%0d", s, lat, e); end
      if (s < 4) pulse_passo();
    end
    checks++; if (db_estado !== 4'd2 || nivel !== 3'd2) begin errors++; $display("FAIL reload_pre got=%0d/%0d exp=2/2", db_estado, nivel); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (db_estado !== 4'd0 || nivel !== 3'd0 || db_periodo !== 8'd8 || fim_espera !== 1'b0 || fim_mapa !== 1'b0)
      begin errors++; $display("FAIL reload_reset got=%0d/%0d/%0d/%b%b exp=0/0/8/00", db_estado, nivel, db_periodo, fim_espera, fim_mapa); end
    carregar(2'b10);
    for (int s = 0; s < 6; s++) begin
      exp_q.push_back(tab_b[s]);
      run_step(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== e) begin errors++; $display("FAIL reload_b%0d_latency got=%0d exp=%0d", s, lat, e); end
      pulse_passo();
    end
    checks++; if (db_estado !== 4'd3 || fim_mapa !== 1'b1) begin errors++; $display("FAIL reload_fim got=%0d/%b exp=3/1", db_estado, fim_mapa); end
    carregar(2'b01);
    checks++; if (fim_mapa !== 1'b0 || db_periodo !== 8'd6 || db_estado !== 4'd0)
      begin errors++; $display("FAIL reload_carrega got=%b/%0d/%0d exp=0/6/0", fim_mapa, db_periodo, db_estado); end
  endtask

  initial begin
    test_reset();
    test_facil();
    test_pause();
    test_level_up();
    test_fim_mapa();
    test_zera();
    test_reset_reload();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
